// File: rtl/con_test_lb_pkg.sv
// rtl/con_test_lb_pkg.sv - shared sizes and kernel weight constants for the 3x3 line-buffer window
package con_test_lb_pkg;

    localparam int IMG_W    = 512;
    localparam int IMG_H    = 512;
    localparam int PIX_W    = 16;
    localparam int RES_W    = 20;
    localparam int CNT_W    = 9;

    localparam int KERNEL_N = 3;
    localparam int KW_W     = 3;

    // Nine 3-bit weights, row-major; both kernels are symmetric so packing order is immaterial.
    localparam logic [KERNEL_N*KERNEL_N*KW_W-1:0] KW_BOX   = {9{3'd1}};
    localparam logic [KERNEL_N*KERNEL_N*KW_W-1:0] KW_GAUSS = {3'd1, 3'd2, 3'd1,
                                                              3'd2, 3'd4, 3'd2,
                                                              3'd1, 3'd2, 3'd1};
    localparam int SHIFT_BOX   = 0;
    localparam int SHIFT_GAUSS = 4;

    function automatic logic [KW_W-1:0] kernel_weight(
        input logic [KERNEL_N*KERNEL_N*KW_W-1:0] kw,
        input int                                k,
        input int                                j
    );
        return kw[(k*KERNEL_N + j)*KW_W +: KW_W];
    endfunction

endpackage

// File: rtl/con_test_lb_linebuf.sv
// rtl/con_test_lb_linebuf.sv - one image row of pixel storage, registered read of the old value at the written index
module con_test_lb_linebuf #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rd_en_i,   // capture mem[addr_i] into rdata_o
    input  logic             wr_en_i,   // overwrite mem[addr_i] with wdata_i
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read-before-write: a same-edge read and write returns the previous row's pixel.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/con_test_lb.sv
// rtl/con_test_lb.sv - 3x3 raster window sum over two line buffers; CON_LB_WEIGHTED_EN selects the 1-2-1 weighted kernel
module con_test_lb #(
    parameter int IMG_W = con_test_lb_pkg::IMG_W,
    parameter int IMG_H = con_test_lb_pkg::IMG_H,
    parameter int PIX_W = con_test_lb_pkg::PIX_W,
    parameter int RES_W = con_test_lb_pkg::RES_W
) (
    input  logic             rst,     // synchronous, active-high
    input  logic             clk,
    input  logic [PIX_W-1:0] din,     // raster-order pixel, valid with i_en
    input  logic             i_en,    // one pixel per high cycle
    output logic [RES_W-1:0] result,  // last complete-window result
    output logic             done     // sticky frame-complete flag
);
    import con_test_lb_pkg::*;

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int ACC_W = PIX_W + 5;

`ifdef CON_LB_WEIGHTED_EN
    localparam logic [KERNEL_N*KERNEL_N*KW_W-1:0] KW     = KW_GAUSS;
    localparam int                                KSHIFT = SHIFT_GAUSS;
`else
    localparam logic [KERNEL_N*KERNEL_N*KW_W-1:0] KW     = KW_BOX;
    localparam int                                KSHIFT = SHIFT_BOX;
`endif

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;

    // Stage 1: the edge after acceptance; line-buffer read data is valid here.
    logic             acc_s1_q, acc_s1_d;
    logic             vld_s1_q, vld_s1_d;
    logic             last_s1_q, last_s1_d;
    logic [PIX_W-1:0] din_s1_q, din_s1_d;
    logic [CW-1:0]    col_s1_q, col_s1_d;

    // Stage 2: window holds the new column; result is computed from it.
    logic             vld_s2_q, vld_s2_d;
    logic             last_s2_q, last_s2_d;

    // win[0] = row r-2, win[1] = row r-1, win[2] = row r; column index 2 is newest.
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];

    logic [RES_W-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             accept;
    logic             col_last;
    logic             row_last;
    logic [CW-1:0]    lb1_addr;
    logic [PIX_W-1:0] lb0_rdata;
    logic [PIX_W-1:0] lb1_rdata;
    logic [ACC_W-1:0] acc;

    // lb0 holds row r-1: read and overwritten with din on the accepting edge.
    con_test_lb_linebuf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb0 (
        .clk     (clk),
        .rd_en_i (accept),
        .wr_en_i (accept),
        .addr_i  (col_q),
        .wdata_i (din),
        .rdata_o (lb0_rdata)
    );

    // lb1 holds row r-2: read on the accepting edge, then written one edge later
    // with the row r-1 pixel that lb0 just returned (pulse spacing keeps the port free).
    assign lb1_addr = acc_s1_q ? col_s1_q : col_q;

    con_test_lb_linebuf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb1 (
        .clk     (clk),
        .rd_en_i (accept),
        .wr_en_i (acc_s1_q),
        .addr_i  (lb1_addr),
        .wdata_i (lb0_rdata),
        .rdata_o (lb1_rdata)
    );

    always_comb begin
        accept   = i_en && !done_q && !rst;
        col_last = (col_q == CW'(IMG_W - 1));
        row_last = (row_q == RW'(IMG_H - 1));

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        acc_s1_d  = accept;
        vld_s1_d  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
        last_s1_d = accept && row_last && col_last;
        din_s1_d  = accept ? din : din_s1_q;
        col_s1_d  = accept ? col_q : col_s1_q;

        vld_s2_d  = vld_s1_q;
        last_s2_d = last_s1_q;

        // The window shifts on every accepted pixel so it is already primed
        // with columns c-2 and c-1 when a complete window arrives.
        win_d = win_q;
        if (acc_s1_q) begin
            for (int k = 0; k < 3; k++) begin
                win_d[k][0] = win_q[k][1];
                win_d[k][1] = win_q[k][2];
            end
            win_d[0][2] = lb1_rdata;
            win_d[1][2] = lb0_rdata;
            win_d[2][2] = din_s1_q;
        end

        acc = '0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                acc = acc + ACC_W'(win_q[k][j]) * ACC_W'(kernel_weight(KW, k, j));
            end
        end

        result_d = vld_s2_q ? RES_W'(acc >> KSHIFT) : result_q;
        done_d   = done_q || last_s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            acc_s1_q  <= 1'b0;
            vld_s1_q  <= 1'b0;
            last_s1_q <= 1'b0;
            din_s1_q  <= '0;
            col_s1_q  <= '0;
            vld_s2_q  <= 1'b0;
            last_s2_q <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[k][j] <= '0;
                end
            end
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            acc_s1_q  <= acc_s1_d;
            vld_s1_q  <= vld_s1_d;
            last_s1_q <= last_s1_d;
            din_s1_q  <= din_s1_d;
            col_s1_q  <= col_s1_d;
            vld_s2_q  <= vld_s2_d;
            last_s2_q <= last_s2_d;
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[k][j] <= win_d[k][j];
                end
            end
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_con_test_lb.sv
// tb/tb_con_test_lb.sv - randomized scoreboard bench for con_test_lb on a reduced 8x6 frame
module tb_con_test_lb;

    localparam int TW   = 8;
    localparam int TH   = 6;
    localparam int PW   = 16;
    localparam int RWD  = 20;
    localparam int NPIX = TW * TH;

    logic           rst;
    logic           clk;
    logic [PW-1:0]  din;
    logic           i_en;
    logic [RWD-1:0] result;
    logic           done;

    con_test_lb #(
        .IMG_W (TW),
        .IMG_H (TH),
        .PIX_W (PW),
        .RES_W (RWD)
    ) dut (
        .rst    (rst),
        .clk    (clk),
        .din    (din),
        .i_en   (i_en),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        longint unsigned val;
        int              due;
        bit              last;
    } exp_t;

    exp_t            q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    bit              in_reset = 1'b1;
    longint unsigned exp_result = 0;
    bit              exp_done = 1'b0;

    int unsigned     img [TH][TW];
    int unsigned     pat [NPIX];
    int              pos = 0;
    bit              frame_closed = 1'b0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: window over the stored frame, weights from the kernel shape.
    function automatic longint unsigned window_value(int r, int c);
        longint unsigned s = 0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
`ifdef CON_LB_WEIGHTED_EN
                s += longint'(img[r-2+dr][c-2+dc]) * ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
`else
                s += longint'(img[r-2+dr][c-2+dc]);
`endif
            end
        end
`ifdef CON_LB_WEIGHTED_EN
        s = s / 16;
`endif
        return s % (longint'(1) << RWD);
    endfunction

    // Called at posedge+2; the pixel is sampled on the next rising edge.
    task automatic send_pixel(input int unsigned val, input int gap);
        exp_t e;
        int   r;
        int   c;
        din  = PW'(val);
        i_en = 1'b1;
        if (!frame_closed) begin
            r = pos / TW;
            c = pos % TW;
            img[r][c] = val;
            if (r >= 2 && c >= 2) begin
                e.val  = window_value(r, c);
                e.due  = cyc + 3;
                e.last = (pos == NPIX - 1);
                q.push_back(e);
            end
            if (pos == NPIX - 1) frame_closed = 1'b1;
            pos++;
        end
        @(posedge clk); #2;
        i_en = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        q.delete();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #2;
        end
        rst          = 1'b0;
        exp_result   = 0;
        exp_done     = 1'b0;
        pos          = 0;
        frame_closed = 1'b0;
        in_reset     = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && q.size() > 0; i++) begin
            @(posedge clk); #2;
        end
        check("queue_drained", q.size(), 0);
    endtask

    // Monitor: pops an expectation on its due cycle, otherwise requires the outputs to hold.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                check("result_update", result, q[0].val);
                check("done_at_update", done, q[0].last || exp_done);
                exp_result = q[0].val;
                exp_done   = exp_done || q[0].last;
                void'(q.pop_front());
            end else begin
                if (q.size() > 0 && q[0].due < cyc) begin
                    check("update_missed", q[0].due, cyc);
                    void'(q.pop_front());
                end
                check("result_hold", result, exp_result);
                check("done_hold", done, exp_done);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        i_en = 1'b0;
        din  = '0;
        @(posedge clk); #2;
        do_reset();
        @(posedge clk); #2;
        check("reset_result", result, 0);
        check("reset_done", done, 0);

        // All ones, tightest spacing.
        for (int i = 0; i < NPIX; i++) send_pixel(1, 3);
        drain();
        check("done_after_ones", done, 1);

        // All full-scale, random spacing.
        do_reset();
        for (int i = 0; i < NPIX; i++) send_pixel(32'hFFFF, $urandom_range(3, 16));
        drain();
        check("done_after_max", done, 1);

        // Column-index ramp.
        do_reset();
        for (int i = 0; i < NPIX; i++) send_pixel(i % TW, 16);
        drain();
        check("done_after_ramp", done, 1);

        // Abort a frame mid-way; in-flight results must be discarded.
        do_reset();
        for (int i = 0; i < 30; i++) send_pixel($urandom_range(0, 65535), $urandom_range(3, 6));
        do_reset();
        @(posedge clk); #2;
        check("midreset_result", result, 0);
        check("midreset_done", done, 0);

        // Same random image at spacing 3 and at spacing 16.
        for (int i = 0; i < NPIX; i++) pat[i] = $urandom_range(0, 65535);
        for (int i = 0; i < NPIX; i++) send_pixel(pat[i], 3);
        drain();
        check("done_after_rand3", done, 1);
        do_reset();
        for (int i = 0; i < NPIX; i++) send_pixel(pat[i], 16);
        drain();
        check("done_after_rand16", done, 1);

        // Pulses after done must be ignored.
        for (int i = 0; i < 6; i++) send_pixel($urandom_range(0, 65535), $urandom_range(3, 5));
        repeat (8) begin
            @(posedge clk); #2;
        end
        check("post_done_result", result, exp_result);
        check("post_done_flag", done, 1);
        check("post_done_queue", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
